// File: rtl/nms_threshold_stream.sv
// nms_threshold_stream: raster-order 3x3 non-maximum suppression along the quantised
// gradient direction, followed by a strong/weak double threshold, two pipeline stages.
module nms_threshold_stream #(
    parameter int NBIT_MAG       = 12,
    parameter int IMG_WIDTH      = 512,
    parameter int IMG_HEIGHT     = 512,
    parameter int LOW_THRESHOLD  = 50,
    parameter int HIGH_THRESHOLD = 100,
    parameter int STRONG_VALUE   = 255,
    parameter int WEAK_VALUE     = 128
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic                i_sof,
    input  logic [NBIT_MAG-1:0] i_mag,
    input  logic [1:0]          i_dir,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [7:0]          o_pixel,
    output logic                o_last
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int DW = NBIT_MAG + 2;

    logic [CW-1:0]       col, p_col;
    logic [RW-1:0]       row, p_row;
    logic                accept, done, at_end;
    logic [DW-1:0]       lb0 [IMG_WIDTH];
    logic [DW-1:0]       lb1 [IMG_WIDTH];
    logic [DW-1:0]       up1;
    logic [NBIT_MAG-1:0] up2;
    logic [NBIT_MAG-1:0] wm [3][3];
    logic [1:0]          dir_e, dir_c;
    logic                s1_valid, s1_last;
    logic [NBIT_MAG-1:0] mc, n_prev, n_next;
    logic                keep;
    logic [7:0]          pix;

    assign i_ready = o_ready;
    assign accept  = i_valid && o_ready;
    // A start-of-frame sample is (0,0) no matter where the counters stand.
    assign p_col   = i_sof ? '0 : col;
    assign p_row   = i_sof ? '0 : row;
    assign done    = p_row >= RW'(2) && p_col >= CW'(2);
    assign at_end  = p_row == RW'(IMG_HEIGHT - 1) && p_col == CW'(IMG_WIDTH - 1);
    assign up1     = lb0[p_col];
    assign up2     = lb1[p_col][NBIT_MAG-1:0];

    // Line buffers and window carry no reset; they are refilled before any use.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb0[p_col] <= {i_dir, i_mag};
            lb1[p_col] <= up1;
            for (int r = 0; r < 3; r++) begin
                wm[r][0] <= wm[r][1];
                wm[r][1] <= wm[r][2];
            end
            wm[0][2] <= up2;
            wm[1][2] <= up1[NBIT_MAG-1:0];
            wm[2][2] <= i_mag;
            dir_e    <= up1[DW-1:NBIT_MAG];
            dir_c    <= dir_e;
        end
    end

    // n_prev is the raster-earlier neighbour (W, NE, N, NW), n_next the later one.
    always_comb begin
        mc     = wm[1][1];
        n_prev = dir_c == 2'd0 ? wm[1][0] : dir_c == 2'd1 ? wm[0][2] : dir_c == 2'd2 ? wm[0][1] : wm[0][0];
        n_next = dir_c == 2'd0 ? wm[1][2] : dir_c == 2'd1 ? wm[2][0] : dir_c == 2'd2 ? wm[2][1] : wm[2][2];
        keep   = mc >= n_prev && mc > n_next;
        pix    = !keep ? 8'd0 :
                 mc >= NBIT_MAG'(HIGH_THRESHOLD) ? 8'(STRONG_VALUE) :
                 mc >= NBIT_MAG'(LOW_THRESHOLD)  ? 8'(WEAK_VALUE) : 8'd0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col      <= '0;
            row      <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            o_valid  <= 1'b0;
            o_pixel  <= '0;
            o_last   <= 1'b0;
        end else if (o_ready) begin
            s1_valid <= accept && done;
            s1_last  <= at_end;
            o_valid  <= s1_valid;
            o_pixel  <= s1_valid ? pix : 8'd0;
            o_last   <= s1_valid && s1_last;
            if (accept) begin
                col <= p_col == CW'(IMG_WIDTH - 1) ? '0 : p_col + 1'b1;
                row <= p_col != CW'(IMG_WIDTH - 1) ? p_row :
                       p_row == RW'(IMG_HEIGHT - 1) ? '0 : p_row + 1'b1;
            end
        end
    end
endmodule
